// File: rtl/serializer_ctrl.sv
// serializer_ctrl: IDLE/STREAM sequencer for a rotate-based parallel-to-serial
// serializer. It loads a frame of INPUT_SIZE words with a single update pulse.
// It then rotates the serializer once per beat, so that word 0 of the frame is
// always at the serial output on the first beat.
// Optional feature macro SERIALIZER_CTRL_REPEAT_EN: the frame is streamed
// repeat_count+1 times. Each repeat relies on the rotate wrapping back to word 0.
// Handshake: a frame is accepted in any cycle where start && in_ready.
// serializer_update is that acceptance. The consumer takes every beat and
// never stalls. busy mirrors the FSM state (1 = STREAM).
module serializer_ctrl #(
    parameter int INPUT_SIZE = 4,
    parameter int REPEAT_W   = 4,
    localparam int IW        = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
`ifdef SERIALIZER_CTRL_REPEAT_EN
    input  logic [REPEAT_W-1:0] repeat_count,
`endif
    output logic          in_ready,
    output logic          serializer_update,
    output logic          serializer_shift,
    output logic          out_valid,
    output logic [IW-1:0] out_index,
    output logic          out_first,
    output logic          out_last,
    output logic          busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_BEAT = IW'(INPUT_SIZE - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] beat_q, beat_d;
`ifdef SERIALIZER_CTRL_REPEAT_EN
    logic [REPEAT_W-1:0] pass_q, pass_d;
    logic [REPEAT_W-1:0] rep_q, rep_d;
`endif

    logic streaming;
    logic pass_first;
    logic pass_last;
    logic frame_end;
    logic accept;

    // Output decode. Reset gates every output immediately, so an aborted
    // frame shows nothing in the cycle that reset is applied.
    always_comb begin
        streaming  = (state_q == STREAM) && !reset;
`ifdef SERIALIZER_CTRL_REPEAT_EN
        pass_first = (pass_q == '0);
        pass_last  = (pass_q == rep_q);
`else
        pass_first = 1'b1;
        pass_last  = 1'b1;
`endif
        frame_end         = streaming && (beat_q == LAST_BEAT) && pass_last;
        in_ready          = !reset && ((state_q == IDLE) || frame_end);
        accept            = start && in_ready;
        serializer_update = accept;
        // The last beat never rotates. This keeps update and shift exclusive
        // when the next frame loads back-to-back.
        serializer_shift  = streaming && !frame_end;
        out_valid         = streaming;
        out_index         = streaming ? beat_q : '0;
        out_first         = streaming && (beat_q == '0) && pass_first;
        out_last          = frame_end;
        busy              = streaming;
    end

    // Next-state logic: the beat counter wraps every INPUT_SIZE beats.
    // The pass counter advances on each wrap.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
`ifdef SERIALIZER_CTRL_REPEAT_EN
        pass_d  = pass_q;
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = STREAM;
                    beat_d  = '0;
`ifdef SERIALIZER_CTRL_REPEAT_EN
                    pass_d  = '0;
                    rep_d   = repeat_count;
`endif
                end
            end
            STREAM: begin
                if (frame_end) begin
                    state_d = accept ? STREAM : IDLE;
                    beat_d  = '0;
`ifdef SERIALIZER_CTRL_REPEAT_EN
                    pass_d  = '0;
                    if (accept) rep_d = repeat_count;
`endif
                end else if (beat_q == LAST_BEAT) begin
                    beat_d = '0;
`ifdef SERIALIZER_CTRL_REPEAT_EN
                    pass_d = pass_q + REPEAT_W'(1);
`endif
                end else begin
                    beat_d = beat_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
`ifdef SERIALIZER_CTRL_REPEAT_EN
            pass_q  <= '0;
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
`ifdef SERIALIZER_CTRL_REPEAT_EN
            pass_q  <= pass_d;
            rep_q   <= rep_d;
`endif
        end
    end

endmodule
